pipe_hazard_ctrl: RTL and testbench

Parametrised hazard and flush controller for the NaiveMIPS datapath. It generalises the fixed four-register stall/flush priority encoder to `NREG` pipeline registers. It adds three things:
- a pending-exception state machine that defers the exception flush while the memory stage is blocked on the data bus;
- a drain mode that empties the pipeline behind a held fetch stage;
- a stall watchdog.

It sits beside the datapath and drives the stall/flush enables of every pipeline register and the PC.

---
 rtl/pipe_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Stall/flush priority encoder for NREG pipeline registers with a
//            deferred-exception FSM, fetch-hold drain mode and stall watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int NREG    = 4,
    parameter int TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREG-1:0] stall_req,
    input  logic            except,
    input  logic            drain_req,
    output logic [NREG-1:0] stall,
    output logic [NREG-1:0] flush,
    output logic            pc_stall,
    output logic            pc_redirect,
    output logic            drained,
    output logic            stall_timeout
);

    localparam int                 c_DW   = (NREG > 2) ? $clog2(NREG) : 1;
    localparam logic [c_DW-1:0]    c_DMAX = c_DW'(NREG - 1);
    localparam logic [0:0]         c_IDLE = 1'b0;
    localparam logic [0:0]         c_PEND = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [NREG-1:0] w_haz_stall;
    logic [NREG-1:0] w_haz_flush;
    logic            w_exc_fire;
    logic            w_commit_busy;
    logic [c_DW-1:0] r_dcnt;
    logic            r_drained;

    assign w_commit_busy = stall_req[NREG-1];

    // Register k is held when any stage at or beyond it requests a stall.
    for (genvar k = 0; k < NREG; k++) begin : g_hold
        assign w_haz_stall[k] = |stall_req[NREG-1:k];
    end

    // The bubble goes into the first register downstream of the held group.
    assign w_haz_flush[0] = 1'b0;
    for (genvar k = 1; k < NREG; k++) begin : g_bubble
        assign w_haz_flush[k] = w_haz_stall[k-1] & ~w_haz_stall[k];
    end

    assign w_exc_fire = ((r_state == c_IDLE && except) || r_state == c_PEND)
                        && !w_commit_busy;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (except && w_commit_busy) w_state_nxt = c_PEND;
            c_PEND:  if (!w_commit_busy)          w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        stall       = w_haz_stall;
        flush       = w_haz_flush;
        pc_stall    = |stall_req;
        pc_redirect = 1'b0;
        if (rst) begin
            flush    = '1;
            stall    = '0;
            pc_stall = 1'b1;
        end else if (w_exc_fire) begin
            flush       = '1;
            stall       = '0;
            pc_stall    = 1'b0;
            pc_redirect = 1'b1;
        end else if (drain_req) begin
            stall[0] = 1'b1;
            pc_stall = 1'b1;
            if (!w_haz_stall[1]) flush[1] = 1'b1;
        end
    end

    // dcnt counts cycles in which everything past fetch was free to advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dcnt    <= '0;
            r_drained <= 1'b0;
        end else begin
            r_drained <= drain_req && (r_dcnt == c_DMAX);
            if (!drain_req)
                r_dcnt <= '0;
            else if (w_exc_fire)
                r_dcnt <= c_DMAX;
            else if (stall_req[NREG-1:1] == '0) begin
                if (r_dcnt != c_DMAX) r_dcnt <= r_dcnt + 1'b1;
            end
        end
    end

    assign drained = r_drained;

    if (TIMEOUT > 0) begin : g_wdog
        localparam int              c_WW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
        localparam logic [c_WW-1:0] c_WLAST = c_WW'(TIMEOUT - 1);
        logic [c_WW-1:0] r_wcnt;
        logic            r_timeout;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wcnt    <= '0;
                r_timeout <= 1'b0;
            end else if (|stall_req) begin
                if (r_wcnt != c_WLAST) r_wcnt <= r_wcnt + 1'b1;
                else                   r_timeout <= 1'b1;
            end else begin
                r_wcnt <= '0;
            end
        end

        assign stall_timeout = r_timeout;
    end else begin : g_no_wdog
        assign stall_timeout = 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed self-checking bench for pipe_hazard_ctrl (NREG=4, TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int c_NREG    = 4;
    localparam int c_TIMEOUT = 8;

    logic              clk;
    logic              rst;
    logic [c_NREG-1:0] stall_req;
    logic              except;
    logic              drain_req;
    logic [c_NREG-1:0] stall;
    logic [c_NREG-1:0] flush;
    logic              pc_stall;
    logic              pc_redirect;
    logic              drained;
    logic              stall_timeout;

    int n_tests;
    int n_fail;

    pipe_hazard_ctrl #(
        .NREG    (c_NREG),
        .TIMEOUT (c_TIMEOUT)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .stall_req     (stall_req),
        .except        (except),
        .drain_req     (drain_req),
        .stall         (stall),
        .flush         (flush),
        .pc_stall      (pc_stall),
        .pc_redirect   (pc_redirect),
        .drained       (drained),
        .stall_timeout (stall_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Settle combinational outputs after input changes, then compare.
    task automatic check_comb(input string tag, input logic [3:0] e_stall,
                              input logic [3:0] e_flush, input logic e_pcs,
                              input logic e_redir);
        #1;
        check({tag, ".stall"},    32'(stall),       32'(e_stall));
        check({tag, ".flush"},    32'(flush),       32'(e_flush));
        check({tag, ".pc_stall"}, 32'(pc_stall),    32'(e_pcs));
        check({tag, ".redir"},    32'(pc_redirect), 32'(e_redir));
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        stall_req = '0;
        except    = 1'b0;
        drain_req = 1'b0;

        // Reset values
        check_comb("rst", 4'b0000, 4'b1111, 1'b1, 1'b0);
        tick();
        tick();
        check("rst.drained", 32'(drained), 32'd0);
        check("rst.timeout", 32'(stall_timeout), 32'd0);
        rst = 1'b0;
        check_comb("idle", 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Hazard priority
        stall_req = 4'b0100;
        check_comb("haz0100", 4'b0111, 4'b1000, 1'b1, 1'b0);
        tick();
        stall_req = 4'b0001;
        check_comb("haz0001", 4'b0001, 4'b0010, 1'b1, 1'b0);
        tick();
        stall_req = 4'b1010;
        check_comb("haz1010", 4'b1111, 4'b0000, 1'b1, 1'b0);
        tick();
        stall_req = 4'b0000;
        tick();

        // Immediate exception flush
        stall_req = 4'b0010;
        except    = 1'b1;
        check_comb("exc_now", 4'b0000, 4'b1111, 1'b0, 1'b1);
        tick();
        except    = 1'b0;
        stall_req = 4'b0000;
        check_comb("exc_after", 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick();

        // Deferred exception with a second pulse ignored in PEND
        stall_req = 4'b1000;
        except    = 1'b1;
        check_comb("pend_in", 4'b1111, 4'b0000, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            except = (i == 0);
            check_comb($sformatf("pend_hold%0d", i), 4'b1111, 4'b0000, 1'b1, 1'b0);
            tick();
        end
        except    = 1'b0;
        stall_req = 4'b0000;
        check_comb("pend_fire", 4'b0000, 4'b1111, 1'b0, 1'b1);
        tick();
        check_comb("pend_once", 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick();

        // Drain with no hazards
        drain_req = 1'b1;
        check_comb("drain", 4'b0001, 4'b0010, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("drained_e%0d", i), 32'(drained), 32'(i == 4));
        end
        drain_req = 1'b0;
        tick();
        check("drained_clr", 32'(drained), 32'd0);

        // Drain delayed one cycle by a mid-drain stall
        drain_req = 1'b1;
        tick();
        stall_req = 4'b0100;
        check_comb("drain_haz", 4'b0111, 4'b1000, 1'b1, 1'b0);
        tick();
        stall_req = 4'b0000;
        for (int i = 3; i <= 5; i++) begin
            tick();
            check($sformatf("drained_d%0d", i), 32'(drained), 32'(i == 5));
        end

        // Exception flush overrides drain
        except = 1'b1;
        check_comb("drain_exc", 4'b0000, 4'b1111, 1'b0, 1'b1);
        tick();
        except    = 1'b0;
        drain_req = 1'b0;
        tick();
        check("drained_clr2", 32'(drained), 32'd0);

        // Watchdog: 7 stall, 1 gap, 7 stall never trips
        for (int i = 0; i < 15; i++) begin
            stall_req = (i == 7) ? 4'b0000 : 4'b0001;
            tick();
        end
        stall_req = 4'b0000;
        tick();
        check("wdog_7gap7", 32'(stall_timeout), 32'd0);

        // Watchdog: 8 consecutive stall cycles trip it
        stall_req = 4'b0001;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i >= 7)
                check($sformatf("wdog_c%0d", i), 32'(stall_timeout), 32'(i == 8));
        end
        stall_req = 4'b0000;
        tick();
        check("wdog_sticky", 32'(stall_timeout), 32'd1);

        // Reset while an exception is pending
        stall_req = 4'b1000;
        except    = 1'b1;
        tick();
        except = 1'b0;
        rst    = 1'b1;
        check_comb("rst_pend", 4'b0000, 4'b1111, 1'b1, 1'b0);
        tick();
        check("rst_timeout", 32'(stall_timeout), 32'd0);
        rst       = 1'b0;
        stall_req = 4'b0000;
        check_comb("post_rst", 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick();
        check_comb("post_rst2", 4'b0000, 4'b0000, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
`default_nettype wire
